armleocpu_mem_1r1w_ctrl: RTL and testbench
==========================================

Name: armleocpu_mem_1r1w_ctrl

Overview:
- Controller in front of one armleocpu 1r1w storage instance, used by the regfile and small CPU-side tables.
- Clears every entry after reset, since the storage array has no reset.
- Shares the single read port between two requesters with round-robin arbitration.
- Passes one write stream through, and returns read responses with fixed 1-cycle latency.

Parameters:
- DEPTH_LOG2, 5, log2 of entry count; ELEMENTS = 2**DEPTH_LOG2.
- WIDTH, 32, data width in bits.
- CLEAR_VALUE, '0, WIDTH-bit value written to every entry during init.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the clear sweep has finished.
- rd0_valid  in  1  requester 0 read request.
- rd0_addr  in  DEPTH_LOG2  requester 0 read address.
- rd0_ready  out  1  requester 0 request accepted this cycle.
- rd0_resp_valid  out  1  requester 0 read data valid.
- rd0_resp_data  out  WIDTH  requester 0 read data.
- rd1_valid, rd1_addr, rd1_ready, rd1_resp_valid, rd1_resp_data: same as rd0_*, for requester 1.
- wr_valid  in  1  write request.
- wr_addr  in  DEPTH_LOG2  write address.
- wr_data  in  WIDTH  write data.
- wr_ready  out  1  write accepted this cycle.
- mem_read  out  1  storage read enable.
- mem_read_addr  out  DEPTH_LOG2  storage read address.
- mem_read_data  in  WIDTH  storage registered read data.
- mem_write  out  1  storage write enable.
- mem_write_addr  out  DEPTH_LOG2  storage write address.
- mem_write_data  out  WIDTH  storage write data.

Behaviour:
- Reset values: state=INIT, clear_cnt=0, rr_ptr=0 (rd0 has priority), init_done=0, rd0_resp_valid=0, rd1_resp_valid=0, bypass register=0.
- The ready and mem_* outputs are combinational from state and requests.
- INIT state:
  - mem_write=1, mem_write_addr=clear_cnt, mem_write_data=CLEAR_VALUE.
  - rd*_ready=0, wr_ready=0, mem_read=0.
  - clear_cnt increments every cycle.
  - On the edge where clear_cnt==ELEMENTS-1, move to RUN and set init_done=1.
  - Sweep takes exactly ELEMENTS cycles; init_done is first seen high in cycle ELEMENTS+1 after reset release.
- RUN state, write path:
  - wr_ready=1.
  - mem_write=wr_valid, mem_write_addr=wr_addr, mem_write_data=wr_data.
  - Writes are never back-pressured in RUN.
- RUN state, read arbitration (at most one grant per cycle):
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by rr_ptr.
  - After any grant to requester i, rr_ptr <= 1-i.
  - No grant: rr_ptr holds.
  - Granted requester: ready=1, mem_read=1, mem_read_addr=its addr. Non-granted requester: ready=0 and must hold its request.
  - With no grant, mem_read=0 and mem_read_addr=rd0_addr (don't care).
- Response:
  - rdI_resp_valid is registered and goes high the cycle after requester I's grant, for exactly one cycle.
  - rdI_resp_data = mem_read_data. It is meaningful only while resp_valid is high and is otherwise unspecified.
  - Both resp_valid outputs are never high together.
- Read-after-write:
  - Write in cycle N, read of the same address granted in cycle N+1 or later returns the new data.
  - Write and read of the same address in the same cycle: see Optional Feature.
- Reset mid-operation:
  - Immediately returns to the reset values above.
  - Any in-flight response is dropped (resp_valid=0).
  - The sweep restarts from address 0.
- Width rules: addresses are DEPTH_LOG2 bits with no wrap beyond ELEMENTS-1. clear_cnt is DEPTH_LOG2 bits.

Optional Feature:
- Macro: ARMLEOCPU_MEM_1R1W_CTRL_BYPASS_EN.
- Defined:
  - On the same cycle as a grant, if wr_valid && wr_ready && wr_addr==granted addr, register a bypass flag and wr_data.
  - Next cycle resp_data = bypassed wr_data instead of mem_read_data, so the response is write-first.
- Not defined:
  - No bypass logic.
  - A same-cycle same-address read returns the old contents, so the response is read-first.
  - The flag and bypass register do not exist.

Decomposition:
- Package armleocpu_mem_ctrl_pkg:
  - state enum {INIT, RUN}.
  - Requester index localparams REQ0=0, REQ1=1.
- One natural sub-module: armleocpu_rr_arbiter2, a 2-way round-robin arbiter holding rr_ptr, with valid[1:0] in and grant[1:0] out.
- Everything else stays in one module.

Test Plan:
- Reset release, DEPTH_LOG2=5 -> mem_write=1 with addr 0..31 in order and data CLEAR_VALUE; init_done=1 in cycle 33; all readys 0 until then.
- rd0_valid addr 3 during INIT -> rd0_ready=0, mem_read=0; after init_done, granted, and next cycle rd0_resp_valid=1 with data 0.
- Write addr 5=0xDEADBEEF, then rd1 read addr 5 one cycle later -> rd1_resp_valid next cycle with 0xDEADBEEF; rd0_resp_valid stays 0.
- rd0 (addr 1) and rd1 (addr 2) valid continuously for 6 cycles, from rr_ptr=0 -> grants rd0,rd1,rd0,rd1,rd0,rd1; responses alternate with one cycle of latency.
- Entry 7 holds 0; same cycle write 7=0x11 and rd0 read 7 -> response 0x0 without the macro, 0x11 with it; a later read returns 0x11 in both builds.
- rst_n low for 1 cycle mid-RUN while rd0 has a response pending -> rd0_resp_valid=0 and init_done=0 immediately; sweep restarts at addr 0; a previously written addr 5 reads back CLEAR_VALUE after the new init.

Source files
------------

// File: rtl/armleocpu_mem_ctrl_pkg.sv
// Shared types for the armleocpu 1r1w storage controller: FSM states and
// read-requester indices.
package armleocpu_mem_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/armleocpu_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester named by rr_ptr, and rr_ptr then points at the loser.
module armleocpu_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic rr_ptr_q, rr_ptr_d;

    // NOTE: every signal written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_o  = valid_i;
        rr_ptr_d = rr_ptr_q;
        if (valid_i == 2'b11) begin
            grant_o = rr_ptr_q ? 2'b10 : 2'b01;
        end
        if (grant_o[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its input from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/armleocpu_mem_1r1w_ctrl.sv
// Controller for one armleocpu 1r1w storage: clear sweep after reset, two
// round-robin read requesters, one write stream. Optional write-first
// same-cycle bypass is enabled by ARMLEOCPU_MEM_1R1W_CTRL_BYPASS_EN.
module armleocpu_mem_1r1w_ctrl
    import armleocpu_mem_ctrl_pkg::*;
#(
    parameter int               DEPTH_LOG2  = 5,
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,

    input  logic                  rd0_valid,
    input  logic [DEPTH_LOG2-1:0] rd0_addr,
    output logic                  rd0_ready,
    output logic                  rd0_resp_valid,
    output logic [WIDTH-1:0]      rd0_resp_data,

    input  logic                  rd1_valid,
    input  logic [DEPTH_LOG2-1:0] rd1_addr,
    output logic                  rd1_ready,
    output logic                  rd1_resp_valid,
    output logic [WIDTH-1:0]      rd1_resp_data,

    input  logic                  wr_valid,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,

    output logic                  mem_read,
    output logic [DEPTH_LOG2-1:0] mem_read_addr,
    input  logic [WIDTH-1:0]      mem_read_data,
    output logic                  mem_write,
    output logic [DEPTH_LOG2-1:0] mem_write_addr,
    output logic [WIDTH-1:0]      mem_write_data
);

    localparam int ELEMENTS = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(ELEMENTS - 1);

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   clear_cnt_q, clear_cnt_d;
    logic                    init_done_q, init_done_d;
    logic [1:0]              resp_valid_q;
    logic [1:0]              req_valid;
    logic [1:0]              grant;
    logic [WIDTH-1:0]        resp_data;

    // Requests are invisible to the arbiter until the sweep has finished.
    assign req_valid = (state_q == RUN) ? {rd1_valid, rd0_valid} : 2'b00;

    armleocpu_rr_arbiter2 u_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (req_valid),
        .grant_o (grant)
    );

    always_comb begin
        rd0_ready      = grant[REQ0];
        rd1_ready      = grant[REQ1];
        mem_read       = |grant;
        mem_read_addr  = grant[REQ1] ? rd1_addr : rd0_addr;
        wr_ready       = (state_q == RUN);
        mem_write      = wr_valid;
        mem_write_addr = wr_addr;
        mem_write_data = wr_data;
        state_d        = state_q;
        clear_cnt_d    = clear_cnt_q;
        init_done_d    = init_done_q;
        if (state_q == INIT) begin
            mem_write      = 1'b1;
            mem_write_addr = clear_cnt_q;
            mem_write_data = CLEAR_VALUE;
            clear_cnt_d    = clear_cnt_q + DEPTH_LOG2'(1);
            if (clear_cnt_q == LAST_ADDR) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // NOTE: only control state is reset here; the storage array itself has
    // no reset and is cleared by the INIT sweep instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            clear_cnt_q  <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= grant;
        end
    end

`ifdef ARMLEOCPU_MEM_1R1W_CTRL_BYPASS_EN
    logic             bypass_q, bypass_d;
    logic [WIDTH-1:0] bypass_data_q;

    // A write landing on the granted address this cycle wins over the
    // storage's read-first data on the following cycle.
    assign bypass_d = mem_read && wr_valid && wr_ready && (wr_addr == mem_read_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            bypass_q      <= bypass_d;
            bypass_data_q <= wr_data;
        end
    end

    assign resp_data = bypass_q ? bypass_data_q : mem_read_data;
`else
    assign resp_data = mem_read_data;
`endif

    assign init_done      = init_done_q;
    assign rd0_resp_valid = resp_valid_q[REQ0];
    assign rd1_resp_valid = resp_valid_q[REQ1];
    assign rd0_resp_data  = resp_data;
    assign rd1_resp_data  = resp_data;

endmodule

// File: tb/tb_armleocpu_mem_1r1w_ctrl.sv
// Self-checking bench for armleocpu_mem_1r1w_ctrl with a behavioural 1r1w
// storage, a shadow content model and a response scoreboard.
module tb_armleocpu_mem_1r1w_ctrl;

    localparam int DL = 5;
    localparam int W  = 32;
    localparam int N  = 32;
    localparam logic [W-1:0] CLR = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          rd0_valid = 1'b0, rd1_valid = 1'b0, wr_valid = 1'b0;
    logic [DL-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd0_ready, rd1_ready, wr_ready;
    logic          rd0_resp_valid, rd1_resp_valid;
    logic [W-1:0]  rd0_resp_data, rd1_resp_data;
    logic          mem_read, mem_write;
    logic [DL-1:0] mem_read_addr, mem_write_addr;
    logic [W-1:0]  mem_read_data, mem_write_data;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic         req;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          v0;
        logic [DL-1:0] a0;
        logic          v1;
        logic [DL-1:0] a1;
        logic          r0;
        logic          r1;
    } vec_t;
    vec_t tbl[6];

    logic [W-1:0] shadow [N];
    logic         m_rr;
    logic         o0, o1;

    always #5 clk = ~clk;

    armleocpu_mem_1r1w_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W), .CLEAR_VALUE(CLR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_done      (init_done),
        .rd0_valid      (rd0_valid),
        .rd0_addr       (rd0_addr),
        .rd0_ready      (rd0_ready),
        .rd0_resp_valid (rd0_resp_valid),
        .rd0_resp_data  (rd0_resp_data),
        .rd1_valid      (rd1_valid),
        .rd1_addr       (rd1_addr),
        .rd1_ready      (rd1_ready),
        .rd1_resp_valid (rd1_resp_valid),
        .rd1_resp_data  (rd1_resp_data),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .mem_read       (mem_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    // Behavioural storage: registered, read-first, no reset.
    logic [W-1:0] mem [N];
    always @(posedge clk) begin
        if (mem_write) mem[mem_write_addr] <= mem_write_data;
        if (mem_read)  mem_read_data <= mem[mem_read_addr];
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (rst_n && (rd0_resp_valid || rd1_resp_valid)) begin
            check("resp_exclusive", W'(rd0_resp_valid & rd1_resp_valid), '0);
            if (sb.size() == 0) begin
                check("resp_unexpected", W'({rd1_resp_valid, rd0_resp_valid}), '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_port", W'(rd1_resp_valid), W'(e.req));
                check("resp_data", rd1_resp_valid ? rd1_resp_data : rd0_resp_data, e.data);
            end
        end
    end

    // Drive one RUN cycle (called just after a posedge), check combinational
    // outputs at the negedge against the bench model, push expected responses.
    task automatic step(input logic v0, input logic [DL-1:0] a0,
                        input logic v1, input logic [DL-1:0] a1,
                        input logic wv, input logic [DL-1:0] wa, input logic [W-1:0] wd,
                        output logic r0, output logic r1);
        logic g0, g1;
        logic [DL-1:0] ga;
        exp_t e;
        rd0_valid = v0; rd0_addr = a0;
        rd1_valid = v1; rd1_addr = a1;
        wr_valid  = wv; wr_addr  = wa; wr_data = wd;
        g0 = v0 && (!v1 || !m_rr);
        g1 = v1 && !g0;
        ga = g1 ? a1 : a0;
        @(negedge clk);
        r0 = rd0_ready;
        r1 = rd1_ready;
        check("rd0_ready", W'(rd0_ready), W'(g0));
        check("rd1_ready", W'(rd1_ready), W'(g1));
        check("mem_read", W'(mem_read), W'(g0 | g1));
        check("wr_ready", W'(wr_ready), W'(1));
        check("mem_write", W'(mem_write), W'(wv));
        if (g0 || g1) check("mem_read_addr", W'(mem_read_addr), W'(ga));
        if (wv) begin
            check("mem_write_addr", W'(mem_write_addr), W'(wa));
            check("mem_write_data", mem_write_data, wd);
        end
        if (g0 || g1) begin
            e.req  = g1;
            e.data = shadow[ga];
`ifdef ARMLEOCPU_MEM_1R1W_CTRL_BYPASS_EN
            if (wv && wa == ga) e.data = wd;
`endif
            sb.push_back(e);
            m_rr = g0;
        end
        if (wv) shadow[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, '0, o0, o1);
    endtask

    task automatic drain(input string name);
        check(name, W'(sb.size()), '0);
        sb.delete();
    endtask

    // Called just after reset release; rd0 requests addr 3 throughout.
    task automatic sweep();
        m_rr = 1'b0;
        for (int i = 0; i < N; i++) shadow[i] = CLR;
        rd0_valid = 1'b1; rd0_addr = 5'd3;
        rd1_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("init_mem_write", W'(mem_write), W'(1));
            check("init_write_addr", W'(mem_write_addr), W'(i));
            check("init_write_data", mem_write_data, CLR);
            check("init_rd0_ready", W'(rd0_ready), '0);
            check("init_wr_ready", W'(wr_ready), '0);
            check("init_mem_read", W'(mem_read), '0);
            check("init_done_low", W'(init_done), '0);
            @(posedge clk);
            #1;
        end
        check("init_done_high", W'(init_done), W'(1));
    endtask

    initial begin
        logic [W-1:0] same_cycle_exp;
        for (int i = 0; i < 6; i++) begin
            tbl[i].v0 = 1'b1; tbl[i].a0 = 5'd1;
            tbl[i].v1 = 1'b1; tbl[i].a1 = 5'd2;
            tbl[i].r0 = (i % 2 == 0);
            tbl[i].r1 = (i % 2 == 1);
        end

        // Reset and clear sweep.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_init_done", W'(init_done), '0);
        check("reset_resp_valid", W'({rd1_resp_valid, rd0_resp_valid}), '0);
        rst_n = 1'b1;
        sweep();

        // Read pending through INIT is granted first cycle of RUN.
        step(1, 5'd3, 0, '0, 0, '0, '0, o0, o1);
        idle(2);
        drain("drain_first_read");

        // Write then read-after-write from requester 1.
        step(0, '0, 0, '0, 1, 5'd5, 32'hDEADBEEF, o0, o1);
        step(0, '0, 1, 5'd5, 0, '0, '0, o0, o1);
        idle(2);
        drain("drain_raw");

        // Continuous contention alternates grants.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, 0, '0, '0, o0, o1);
            check($sformatf("tbl%0d_rd0_ready", i), W'(o0), W'(tbl[i].r0));
            check($sformatf("tbl%0d_rd1_ready", i), W'(o1), W'(tbl[i].r1));
        end
        idle(2);
        drain("drain_rr");

        // Same-cycle write and read of entry 7.
`ifdef ARMLEOCPU_MEM_1R1W_CTRL_BYPASS_EN
        same_cycle_exp = 32'h11;
`else
        same_cycle_exp = 32'h0;
`endif
        check("same_cycle_model", shadow[7], 32'h0);
        step(1, 5'd7, 0, '0, 1, 5'd7, 32'h11, o0, o1);
        check("same_cycle_sb", sb[0].data, same_cycle_exp);
        idle(1);
        step(1, 5'd7, 0, '0, 0, '0, '0, o0, o1);
        idle(2);
        drain("drain_same_cycle");

        // Reset while rd0 has a response pending.
        step(1, 5'd5, 0, '0, 0, '0, '0, o0, o1);
        rst_n = 1'b0;
        #1;
        check("midreset_resp_valid", W'(rd0_resp_valid), '0);
        check("midreset_init_done", W'(init_done), '0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep();
        step(1, 5'd5, 0, '0, 0, '0, '0, o0, o1);
        check("after_reset_addr5", sb[0].data, CLR);
        idle(2);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
